// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = 8;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard sources in, stall/flush controls out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  import hazard_pkg::*;

  logic [REG_W-1:0] id_rs1_addr;
  logic [REG_W-1:0] id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic             ex_write_reg_enable;
  logic [REG_W-1:0] ex_rd_addr;
  logic             ex_branch_taken;
  logic             me_mem_req;
  logic             dmem_ready;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_me_stall;
  logic             me_wb_bubble;
  logic             watchdog_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: presents hazard sources, consumes controls.
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_write_reg_enable, ex_rd_addr, ex_branch_taken,
           me_mem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_me_stall, me_wb_bubble, watchdog_err, stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_write_reg_enable, ex_rd_addr, ex_branch_taken,
           me_mem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_me_stall, me_wb_bubble, watchdog_err, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Wrapping event counter with synchronous reset.
module hazard_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles; wraps naturally at 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage core: load-use, taken branch,
// data-memory wait freeze, wait watchdog and performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err;

  logic mem_busy;
  logic load_use;
  logic freeze;
  logic branch_sel;
  logic load_sel;

  // Hazard detection; the freeze also covers MEM_WAIT since mem_busy holds there.
  always_comb begin
    mem_busy   = bus.me_mem_req & ~bus.dmem_ready;
    load_use   = bus.ex_mem_read & bus.ex_write_reg_enable &
                 (bus.ex_rd_addr != REG_ZERO) &
                 ((bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                  (bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr)));
    freeze     = ~rst & ((st == HALT) | mem_busy);
    branch_sel = ~rst & ~freeze & bus.ex_branch_taken;
    load_sel   = ~rst & ~freeze & ~bus.ex_branch_taken & load_use;
  end

  // Same-cycle pipeline controls, priority freeze > branch > load-use.
  always_comb begin
    bus.pc_stall     = freeze | load_sel;
    bus.if_id_stall  = freeze | load_sel;
    bus.if_id_flush  = branch_sel;
    bus.id_ex_stall  = freeze;
    bus.id_ex_flush  = branch_sel | load_sel;
    bus.ex_me_stall  = freeze;
    bus.me_wb_bubble = freeze;
  end

  // Memory-wait FSM with watchdog; HALT is left only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      unique case (st)
        RUN: begin
          if (mem_busy) begin
            st       <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_busy) begin
            st       <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            st  <= HALT;
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        HALT: begin
          st <= HALT;
        end
        default: begin
          st       <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.watchdog_err = err;

  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.pc_stall),
    .count (bus.stall_cycles)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (branch_sel),
    .count (bus.flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_hazard_ctrl;

  // Control vector order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_me_stall, me_wb_bubble
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1101011;
  localparam logic [6:0] C_BRANCH = 7'b0010100;
  localparam logic [6:0] C_LOAD   = 7'b1100100;

  typedef struct packed {
    logic [6:0] ctrl;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       chk;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue its expected response.
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rd,
                     input logic lu, input logic bt, input logic req, input logic rdy,
                     input logic [6:0] ctrl, input logic err, input int sc, input int fc,
                     input logic chk);
    exp_t e;
    rst                     = r;
    bus.id_rs1_addr         = rs1;
    bus.id_rs2_addr         = 5'd7;
    bus.id_uses_rs1         = 1'b1;
    bus.id_uses_rs2         = 1'b1;
    bus.ex_mem_read         = lu;
    bus.ex_write_reg_enable = lu;
    bus.ex_rd_addr          = rd;
    bus.ex_branch_taken     = bt;
    bus.me_mem_req          = req;
    bus.dmem_ready          = rdy;
    e.ctrl = ctrl;
    e.err  = err;
    e.sc   = 4'(sc);
    e.fc   = 4'(fc);
    e.chk  = chk;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle presents a response; pop and compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
             bus.id_ex_flush, bus.ex_me_stall, bus.me_wb_bubble};
      n_checks++;
      if (act !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
      end
      if (e.chk) begin
        n_checks += 3;
        if (bus.watchdog_err !== e.err) begin
          n_fail++;
          $display("FAIL watchdog_err t=%0t got=%b want=%b", $time, bus.watchdog_err, e.err);
        end
        if (bus.stall_cycles !== e.sc) begin
          n_fail++;
          $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, bus.stall_cycles, e.sc);
        end
        if (bus.flush_count !== e.fc) begin
          n_fail++;
          $display("FAIL flush_count t=%0t got=%0d want=%0d", $time, bus.flush_count, e.fc);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_write_reg_enable = 1'b0; bus.ex_rd_addr = '0;
    bus.ex_branch_taken = 1'b0; bus.me_mem_req = 1'b0; bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset
    cyc(1, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 0, 0, 0);
    cyc(1, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 0, 0, 1);
    // Load-use via rs1, then via rs2, x0 and non-load cases
    cyc(0, 5'd5, 5'd5, 1, 0, 0, 0, C_LOAD,   0, 0, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 1, 0, 1);
    cyc(0, 5'd0, 5'd0, 1, 0, 0, 0, C_NONE,   0, 1, 0, 1);
    cyc(0, 5'd5, 5'd7, 1, 0, 0, 0, C_LOAD,   0, 1, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 2, 0, 1);
    // Branch overrides load-use
    cyc(0, 5'd5, 5'd5, 1, 1, 0, 0, C_BRANCH, 0, 2, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 2, 1, 1);
    // Memory wait of 3 cycles with a branch held across it
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 2, 1, 1);
    cyc(0, 5'd5, 5'd5, 0, 1, 1, 0, C_FREEZE, 0, 3, 1, 1);
    cyc(0, 5'd5, 5'd5, 0, 1, 1, 0, C_FREEZE, 0, 4, 1, 1);
    cyc(0, 5'd5, 5'd5, 0, 1, 1, 1, C_BRANCH, 0, 5, 1, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 5, 2, 1);
    // Reset mid-wait with wait_cnt=2
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 5, 2, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 6, 2, 1);
    cyc(1, 5'd5, 5'd5, 0, 0, 1, 0, C_NONE,   0, 7, 2, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 0, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 1, C_NONE,   0, 0, 0, 1);
    // Request withdrawn during wait returns to RUN
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 0, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 1, 0, 1);
    cyc(0, 5'd5, 5'd5, 1, 0, 0, 0, C_LOAD,   0, 1, 0, 1);
    // Watchdog trips after MAX_WAIT+1 busy cycles; HALT ignores ready/branch
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 2, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 3, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 4, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 5, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 0, C_FREEZE, 0, 6, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 1, 1, C_FREEZE, 1, 7, 0, 1);
    cyc(0, 5'd5, 5'd5, 1, 1, 0, 0, C_FREEZE, 1, 8, 0, 1);
    cyc(1, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   1, 9, 0, 1);
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 0, 0, 1);
    // Counter wrap: 17 load-use cycles on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      cyc(0, 5'd5, 5'd5, 1, 0, 0, 0, C_LOAD, 0, i % 16, 0, 1);
    end
    cyc(0, 5'd5, 5'd5, 0, 0, 0, 0, C_NONE,   0, 1, 0, 1);

    // Drain the scoreboard, bounded
    for (int k = 0; k < 4 && q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
